// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    return (v == SEL_W'(N - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Purely combinational N:1 data mux shared by all channels.
module mux_n1_data #(
  parameter int unsigned N      = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic [N*DATA_W-1:0] i_data_in,
  input  logic [SEL_W-1:0]    i_sel,
  output logic [DATA_W-1:0]   o_data
);

  logic [DATA_W-1:0] w_ch [N];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_ch[i] = i_data_in[i*DATA_W +: DATA_W];
    end
  end

  assign o_data = w_ch[i_sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared N:1 mux onto a single valid/ready port.
module rr_mux_arbiter #(
  parameter int unsigned N      = rr_mux_arbiter_pkg::N,
  parameter int unsigned SEL_W  = rr_mux_arbiter_pkg::SEL_W,
  parameter int unsigned DATA_W = rr_mux_arbiter_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] data_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic [N-1:0]        grant
);

  import rr_mux_arbiter_pkg::*;

  state_e           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic             r_valid, w_valid_nxt;

  logic             w_hs;
  logic [SEL_W-1:0] w_scan_ptr;
  logic [N-1:0]     w_req_m;
  logic             w_found;
  logic [SEL_W-1:0] w_win;
  logic [N-1:0]     w_onehot;

  // On a handshake the scan starts past the served channel, which is masked out.
  always_comb begin
    w_hs       = (r_state == GRANT) && r_valid && out_ready;
    w_scan_ptr = w_hs ? wrap_inc(r_sel) : r_ptr;
    w_req_m    = req;
    if (w_hs) begin
      w_req_m[r_sel] = 1'b0;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_req_m[w_scan_ptr + SEL_W'(k)]) begin
        w_found = 1'b1;
        w_win   = w_scan_ptr + SEL_W'(k);
      end
    end
    w_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_win;
          w_grant_nxt = w_onehot;
          w_valid_nxt = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_hs) begin
          w_ptr_nxt = wrap_inc(r_sel);
          if (w_found) begin
            w_sel_nxt   = w_win;
            w_grant_nxt = w_onehot;
          end else begin
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign out_valid = r_valid;
  assign out_sel   = r_sel;
  assign grant     = r_grant;

  mux_n1_data #(
    .N      (N),
    .SEL_W  (SEL_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .i_data_in (data_in),
    .i_sel     (r_sel),
    .o_data    (out_data)
  );

endmodule
